// File: rtl/exmem_pkg.sv
// ============================================================================
// exmem_pkg : shared widths, control-bit indices, state and payload types
//             for the EX/MEM valid/ready stage.
// Rev 1.0
// ============================================================================
`default_nettype none

package exmem_pkg;

    localparam int EXMEM_N     = 32;
    localparam int EXMEM_MEM_W = 3;
    localparam int EXMEM_WB_W  = 2;
    localparam int EXMEM_RW    = 5;

    localparam int WB_REGWRITE  = 1;
    localparam int MEM_MEMREAD  = 0;
    localparam int MEM_MEMWRITE = 1;
    localparam int MEM_BRANCH   = 2;

    // Encoding is {main_valid, skid_valid}; 2'b01 never occurs.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } skid_state_e;

    typedef struct packed {
        logic [EXMEM_MEM_W-1:0] mem_ctrl;
        logic [EXMEM_WB_W-1:0]  wb_ctrl;
        logic [EXMEM_N-1:0]     alu;
        logic [EXMEM_N-1:0]     store;
        logic [EXMEM_RW-1:0]    rd;
    } exmem_payload_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// pipe_skid_buf : generic 2-entry skid register; in_ready is purely registered.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_skid_buf
    import exmem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         w_acc, w_pop;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        w_acc   = in_valid & in_ready;
        w_pop   = out_valid & out_ready;
        case (state_q)
            ST_EMPTY: begin
                if (w_acc) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (w_acc && w_pop) begin
                    main_d = in_data;
                end else if (w_acc) begin
                    state_d = ST_TWO;
                    skid_d  = in_data;
                end else if (w_pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops everything held and refuses the offered input.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_skid_stage.sv
// ============================================================================
// ex_mem_skid_stage : EX->MEM valid/ready stage with bubble masking, forwarding
//                     tap and optional perf counters (EXMEM_PERF_CNT_EN).
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_mem_skid_stage
    import exmem_pkg::*;
#(
    parameter int N     = EXMEM_N,
    parameter int MEM_W = EXMEM_MEM_W,
    parameter int WB_W  = EXMEM_WB_W,
    parameter int RW    = EXMEM_RW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MEM_W-1:0] mem_ctrl_in,
    input  logic [WB_W-1:0]  wb_ctrl_in,
    input  logic [N-1:0]     alu_in,
    input  logic [N-1:0]     store_in,
    input  logic [RW-1:0]    rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MEM_W-1:0] mem_ctrl_out,
    output logic [WB_W-1:0]  wb_ctrl_out,
    output logic [N-1:0]     alu_out,
    output logic [N-1:0]     store_out,
    output logic [RW-1:0]    rd_out,
    output logic             fwd_valid,
    output logic [RW-1:0]    fwd_rd,
    output logic [N-1:0]     fwd_data
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam int PW = MEM_W + WB_W + 2 * N + RW;

    logic [PW-1:0]    w_in_data, w_out_data;
    logic [MEM_W-1:0] w_mem_ctrl;
    logic [WB_W-1:0]  w_wb_ctrl;

    assign w_in_data = {mem_ctrl_in, wb_ctrl_in, alu_in, store_in, rd_in};

    pipe_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign {w_mem_ctrl, w_wb_ctrl, alu_out, store_out, rd_out} = w_out_data;

    // Control is zeroed on a bubble so MEM/WB never act on stale payload.
    assign mem_ctrl_out = out_valid ? w_mem_ctrl : '0;
    assign wb_ctrl_out  = out_valid ? w_wb_ctrl  : '0;

    assign fwd_valid = out_valid & wb_ctrl_out[WB_REGWRITE] & (rd_out != '0);
    assign fwd_rd    = rd_out;
    assign fwd_data  = alu_out;

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        // A valid main entry is present whenever anything is held.
        if (flush && out_valid && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_skid_stage.sv
// ============================================================================
// tb_ex_mem_skid_stage : directed + random checks against a 2-deep FIFO model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_skid_stage;
    import exmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  mem_ctrl_in, mem_ctrl_out;
    logic [1:0]  wb_ctrl_in, wb_ctrl_out;
    logic [31:0] alu_in, store_in, alu_out, store_out, fwd_data;
    logic [4:0]  rd_in, rd_out, fwd_rd;
    logic        fwd_valid;
`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    exmem_payload_t q[$];
    logic [31:0] m_stall = 0, m_flush = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_ctrl_in  (mem_ctrl_in),
        .wb_ctrl_in   (wb_ctrl_in),
        .alu_in       (alu_in),
        .store_in     (store_in),
        .rd_in        (rd_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mem_ctrl_out (mem_ctrl_out),
        .wb_ctrl_out  (wb_ctrl_out),
        .alu_out      (alu_out),
        .store_out    (store_out),
        .rd_out       (rd_out),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data)
`ifdef EXMEM_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        mem_ctrl_in = 3'($urandom);
        wb_ctrl_in  = 2'($urandom);
        alu_in      = $urandom;
        store_in    = $urandom;
        rd_in       = 5'($urandom);
    endtask

    // Reference: a FIFO of at most two entries, in_ready = room before the edge.
    task automatic model_update();
        exmem_payload_t cur;
        bit acc, pop;
        cur = '{mem_ctrl: mem_ctrl_in, wb_ctrl: wb_ctrl_in, alu: alu_in,
                store: store_in, rd: rd_in};
        acc = in_valid && (q.size() < 2);
        pop = (q.size() > 0) && out_ready;
        if (!rst_n) begin
            m_stall = 0;
            m_flush = 0;
            q.delete();
        end else begin
            if (q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (flush && q.size() > 0 && m_flush != 32'hFFFF_FFFF) m_flush++;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(cur);
            end
        end
    endtask

    task automatic compare_all();
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("alu_out", 64'(alu_out), 64'(q[0].alu));
            chk("store_out", 64'(store_out), 64'(q[0].store));
            chk("rd_out", 64'(rd_out), 64'(q[0].rd));
            chk("mem_ctrl", 64'(mem_ctrl_out), 64'(q[0].mem_ctrl));
            chk("wb_ctrl", 64'(wb_ctrl_out), 64'(q[0].wb_ctrl));
            chk("fwd_valid", 64'(fwd_valid), 64'(q[0].wb_ctrl[1] && q[0].rd != 0));
            chk("fwd_rd", 64'(fwd_rd), 64'(q[0].rd));
            chk("fwd_data", 64'(fwd_data), 64'(q[0].alu));
        end else begin
            chk("mem_ctrl_bubble", 64'(mem_ctrl_out), 64'd0);
            chk("wb_ctrl_bubble", 64'(wb_ctrl_out), 64'd0);
            chk("fwd_valid_bubble", 64'(fwd_valid), 64'd0);
        end
`ifdef EXMEM_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic push(input logic [31:0] alu);
        rand_payload();
        alu_in   = alu;
        in_valid = 1'b1;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rand_payload();

        // Reset with input offered
        in_valid = 1'b1;
        cycle(); cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        cycle();
        chk("rst_alu", 64'(alu_out), 64'd0);
        chk("rst_store", 64'(store_out), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(32'(i));
            chk("stream_alu", 64'(alu_out), 64'(i));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0; cycle();

        // Back-pressure
        out_ready = 1'b0;
        push(32'h11);
        push(32'h22);
        chk("bp_full", 64'(in_ready), 64'd0);
        push(32'h33);
        push(32'h33);
        chk("bp_hold_a", 64'(alu_out), 64'h11);
        out_ready = 1'b1;
        cycle();
        chk("bp_b", 64'(alu_out), 64'h22);
        cycle();
        chk("bp_c", 64'(alu_out), 64'h33);
        in_valid = 1'b0;
        cycle(); cycle();

        // Flush while full
        out_ready = 1'b0;
        push(32'hA);
        push(32'hB);
        flush = 1'b1;
        push(32'hD);
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_mem", 64'(mem_ctrl_out), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle();
        chk("flush_no_d", 64'(out_valid), 64'd0);

        // Forwarding tap
        rand_payload();
        wb_ctrl_in = 2'b10; rd_in = 5'd5; alu_in = 32'hDEAD; in_valid = 1'b1;
        cycle();
        chk("fwd_hit", 64'(fwd_valid), 64'd1);
        chk("fwd_rd5", 64'(fwd_rd), 64'd5);
        chk("fwd_dead", 64'(fwd_data), 64'hDEAD);
        rd_in = 5'd0;
        cycle();
        chk("fwd_rd0", 64'(fwd_valid), 64'd0);
        rd_in = 5'd5; wb_ctrl_in = 2'b01;
        cycle();
        chk("fwd_norw", 64'(fwd_valid), 64'd0);
        in_valid = 1'b0; cycle();

`ifdef EXMEM_PERF_CNT_EN
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        out_ready = 1'b0;
        push(32'h77);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("stall_10", 64'(stall_cnt), 64'd10);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFF_FFFF;
        cycle(); cycle(); cycle();
        chk("stall_sat", 64'(stall_cnt), 64'hFFFF_FFFF);
        out_ready = 1'b1; cycle();
`endif

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            rand_payload();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            rst_n     = ($urandom % 100) != 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
